// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [7:0] byte_t;
    // Index 0 is the most significant byte, matching AES column-major byte order.
    typedef logic [0:3][7:0] col_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_col_mix.sv
// Combinational one-column (Inv)MixColumns multiply; no latency, no flow control.
// Forward matrix and the fwd_i select exist only when INV_MIX_FWD_EN is defined.
module gf_col_mix
    import aes_pkg::*;
(
    input  col_t col_i,
`ifdef INV_MIX_FWD_EN
    input  logic fwd_i,
`endif
    output col_t col_o
);

    byte_t x1 [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];
    byte_t m9 [4];
    byte_t mb [4];
    byte_t md [4];
    byte_t me [4];
    col_t  inv_col;

    for (genvar j = 0; j < 4; j++) begin : g_byte
        assign x1[j] = col_i[j];
        assign x2[j] = xtime(x1[j]);
        assign x4[j] = xtime(x2[j]);
        assign x8[j] = xtime(x4[j]);
        assign m9[j] = x8[j] ^ x1[j];
        assign mb[j] = x8[j] ^ x2[j] ^ x1[j];
        assign md[j] = x8[j] ^ x4[j] ^ x1[j];
        assign me[j] = x8[j] ^ x4[j] ^ x2[j];
    end

    // Each output row is the {0e,0b,0d,09} row rotated right by its index.
    assign inv_col[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign inv_col[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign inv_col[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign inv_col[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

`ifdef INV_MIX_FWD_EN
    col_t fwd_col;

    assign fwd_col[0] = x2[0] ^ x2[1] ^ x1[1] ^ x1[2] ^ x1[3];
    assign fwd_col[1] = x1[0] ^ x2[1] ^ x2[2] ^ x1[2] ^ x1[3];
    assign fwd_col[2] = x1[0] ^ x1[1] ^ x2[2] ^ x2[3] ^ x1[3];
    assign fwd_col[3] = x2[0] ^ x1[0] ^ x1[1] ^ x1[2] ^ x2[3];

    assign col_o = fwd_i ? fwd_col : inv_col;
`else
    assign col_o = inv_col;
`endif

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative InvMixColumns, one column per cycle: result valid 4 edges after accept.
// Holds out_data in DONE until out_ready; no input accepted while busy. INV_MIX_FWD_EN adds fwd mode.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef INV_MIX_FWD_EN
    ,
    input  logic         fwd
`endif
);

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] data_q, data_d;
    // Keeps in_ready low for the reset cycle itself, rising at the first edge out of reset.
    logic         rdy_q;
    col_t         cur_col;
    col_t         mixed_col;

`ifdef INV_MIX_FWD_EN
    logic         mode_q, mode_d;
`endif

    always_comb begin
        cur_col = data_q[127:96];
        case (col_q)
            2'd0:    cur_col = data_q[127:96];
            2'd1:    cur_col = data_q[95:64];
            2'd2:    cur_col = data_q[63:32];
            default: cur_col = data_q[31:0];
        endcase
    end

    gf_col_mix u_gf_col_mix (
        .col_i (cur_col),
`ifdef INV_MIX_FWD_EN
        .fwd_i (mode_q),
`endif
        .col_o (mixed_col)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
`ifdef INV_MIX_FWD_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    data_d  = in_data;
                    col_d   = 2'd0;
                    state_d = BUSY;
`ifdef INV_MIX_FWD_EN
                    mode_d  = fwd;
`endif
                end
            end
            BUSY: begin
                case (col_q)
                    2'd0:    data_d[127:96] = mixed_col;
                    2'd1:    data_d[95:64]  = mixed_col;
                    2'd2:    data_d[63:32]  = mixed_col;
                    default: data_d[31:0]   = mixed_col;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
`ifdef INV_MIX_FWD_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
            rdy_q   <= 1'b1;
`ifdef INV_MIX_FWD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && rdy_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed-vector and model-based bench for inv_mix_columns.
module tb_inv_mix_columns;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         fwd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inv_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef INV_MIX_FWD_EN
        ,
        .fwd       (fwd)
`endif
    );

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] model_col(input logic [31:0] c, input logic f);
        logic [7:0]  a [4];
        logic [7:0]  k [4];
        logic [7:0]  b;
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        if (f) k = '{8'h02, 8'h03, 8'h01, 8'h01};
        else   k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gf_mul(k[(j - row + 4) % 4], a[j]);
            r[31-8*row -: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s, input logic f);
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(s[127-32*c -: 32], f);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, wait (bounded) for out_valid, then complete the output handshake.
    task automatic run_block(input logic [127:0] din, input logic f,
                             output logic [127:0] dout, output int lat);
        int k;
        lat  = -1;
        dout = '0;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        in_data  = din;
        fwd      = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        if (lat > 0) begin
            dout      = out_data;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    vec_t         vecs [8];
    logic [127:0] res, res2, held, r;
    int           lat, lat2;
    logic [127:0] exp_q [$];
    int           last_cyc, n_out;
    logic         acc;

    initial begin
        vecs[0] = '{"fips_col0",  {32'h8e4da1bc, 96'h0},
                                  {32'hdb135345, 96'h0}};
        vecs[1] = '{"col1_pos",   {32'h0, 32'h4d7ebdf8, 64'h0},
                                  {32'h0, 32'h2d26314c, 64'h0}};
        vecs[2] = '{"col2_pos",   {64'h0, 32'h9fdc589d, 32'h0},
                                  {64'h0, 32'hf20a225c, 32'h0}};
        vecs[3] = '{"col3_pos",   {96'h0, 32'hd5d5d7d6},
                                  {96'h0, 32'hd4d4d4d5}};
        vecs[4] = '{"all_01",     {4{32'h01010101}}, {4{32'h01010101}}};
        vecs[5] = '{"all_c6",     {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
        vecs[6] = '{"mixed_cols", {32'h8e4da1bc, 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6},
                                  {32'hdb135345, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6}};
        vecs[7] = '{"all_zero",   128'h0, 128'h0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        fwd       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_in_ready",  in_ready, 0);
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Directed vectors
        foreach (vecs[i]) begin
            run_block(vecs[i].din, 1'b0, res, lat);
            check({vecs[i].name, "_data"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, lat, 4);
            check({vecs[i].name, "_rdy_after"}, in_ready, 1);
        end

        // Backpressure: output held, second request ignored
        in_data  = vecs[0].din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        check("bp_lat", lat, 4);
        held = out_data;
        check("bp_data", held, vecs[0].exp);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = vecs[1].din;
            tick();
            check("bp_stable", out_data, held);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_rdy", in_ready, 1);
        check("bp_release_vld", out_valid, 0);
        tick();
        tick();
        check("bp_not_queued", out_valid, 0);

        // Reset during BUSY
        in_data  = vecs[6].din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        check("midrst_rdy_back", in_ready, 1);
        run_block(vecs[6].din, 1'b0, res, lat);
        check("midrst_new_data", res, vecs[6].exp);
        check("midrst_new_lat", lat, 4);

`ifdef INV_MIX_FWD_EN
        // Forward/inverse round trip
        run_block({32'hdb135345, 96'h0}, 1'b1, res, lat);
        check("fwd_fips", res, {32'h8e4da1bc, 96'h0});
        run_block(res, 1'b0, res2, lat2);
        check("fwd_roundtrip", res2, {32'hdb135345, 96'h0});
        for (int n = 0; n < 1000; n++) begin
            r = rand128();
            run_block(r, 1'b1, res, lat);
            check("rand_fwd", res, model_state(r, 1'b1));
            run_block(res, 1'b0, res2, lat2);
            check("rand_roundtrip", res2, r);
        end
`else
        for (int n = 0; n < 1000; n++) begin
            r = rand128();
            run_block(r, 1'b0, res, lat);
            check("rand_inv", res, model_state(r, 1'b0));
        end
`endif

        // Streaming with in_valid and out_ready held high
        fwd       = 1'b0;
        in_data   = rand128();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last_cyc  = -1;
        n_out     = 0;
        for (int cyc = 0; cyc <= 80; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) check("stream_data", out_data, exp_q.pop_front());
                else                  check("stream_spurious", 1, 0);
                if (last_cyc >= 0) check("stream_period", cyc - last_cyc, 6);
                last_cyc = cyc;
                n_out++;
            end
            acc = in_ready;
            if (acc) exp_q.push_back(model_state(in_data, 1'b0));
            tick();
            if (acc) in_data = rand128();
        end
        in_valid = 1'b0;
        check("stream_count", n_out, 13);
        for (int k = 0; k < 10; k++) tick();
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns.md
# inv_mix_columns

Iterative AES InvMixColumns stage for the decryption datapath. It accepts a 128-bit state and multiplies each 4-byte column by the fixed GF(2^8) matrix {0e,0b,0d,09}, processing one column per clock. It returns the result through a valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse cipher, mirroring the encryption-side mixColumns stage.

## Interface
- No parameters; the datapath is fixed at 128 bits, 4 columns × 4 bytes.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_data carries a state to be transformed.
- in_ready  output  1  block can accept a state; high only in IDLE.
- in_data  input  128  input state; byte i = in_data[127-8i -: 8], column c = bytes 4c..4c+3 (AES column-major).
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  result, same byte ordering as in_data.
- fwd  input  1  present only with INV_MIX_FWD_EN (see Configuration).

## Operation
- FSM states:
  - IDLE: in_ready=1. If in_valid, latch in_data into the state register, clear col to 0, go to BUSY.
  - BUSY: each cycle transform column col in place and increment col. When col==3 is written, go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE.
- Per-column math, with a0..a3 the column bytes:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3.
  - b1, b2 and b3 use the same row rotated right by one byte each.
- GF rules:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2, x4 and x8 are successive xtimes.
  - All operands are 8-bit; there is no carry beyond bit 7.
- out_data is driven directly from the state register. It is stable and unchanged while out_valid=1 and out_ready=0.
- in_ready is low in BUSY and DONE. An in_valid pulse in those states is ignored, not queued.
- Upstream may drop in_valid while in_ready=0 with no effect. Downstream may hold out_ready high permanently.
- col is a 2-bit counter. It wraps 3→0 on the DONE transition and is not otherwise used in IDLE or DONE.

## Timing
- Reset (rst=0 at a clock edge):
  - state=IDLE, col=0, state register=0.
  - out_valid=0, out_data=0.
  - in_ready=0 during reset; it rises at the first edge with rst=1.
  - Reset applies from any state. A mid-BUSY or mid-DONE result is discarded with no output.
- Latency: the accept edge is edge 0. Columns 0..3 are written at edges 1..4. out_valid=1 after edge 4.
- Output handshake: completes at the first edge with out_valid & out_ready, earliest edge 5. in_ready=1 after that edge.
- Throughput: at most one block per 6 cycles. Back-to-back acceptance with the output handshake in the same cycle is not supported.
- rst has priority over every handshake at the same edge.

## Configuration
- INV_MIX_FWD_EN defined:
  - The fwd port exists and is sampled at the accept edge into a mode flag held for the whole block.
  - fwd=1 selects the forward matrix {02,03,01,01}, which reuses the xtime chain: 02=x2, 03=x2^x.
  - fwd=0 selects the inverse matrix.
  - The mode flag resets to 0.
- INV_MIX_FWD_EN undefined:
  - No fwd port.
  - Inverse matrix only.
  - No forward-matrix logic is synthesized.

## Structure
- Shared package aes_pkg:
  - AES_POLY = 8'h1b.
  - Byte type and 4-byte column type.
  - FSM state enum {IDLE, BUSY, DONE}.
  - Function xtime.
- Sub-module gf_col_mix (combinational):
  - Takes one 32-bit column (and mode when INV_MIX_FWD_EN is defined) and returns the transformed column.
  - Instantiated once.
  - The parent owns the FSM, col counter, state register and handshakes.

## Test plan
- FIPS-197 column: column 0 = 8e 4d a1 bc, other columns 0 → out column 0 = db 13 53 45, others 0; out_valid exactly 4 cycles after the accept edge.
- Column 4d 7e bd f8 → 2d 26 31 4c; column 01 01 01 01 → 01 01 01 01; column c6 c6 c6 c6 → c6 c6 c6 c6. Place one vector in each column position to check byte ordering.
- Backpressure: hold out_ready=0 for 10 cycles → out_data stable, in_ready=0, a second in_valid is ignored. Release → handshake, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst=0 at edge 2 of BUSY → next cycle out_valid=0, out_data=0, col=0. First rst=1 edge → in_ready=1. A new block completes correctly.
- Round trip with INV_MIX_FWD_EN: fwd=1 on db 13 53 45 → 8e 4d a1 bc. Feed the result back with fwd=0 → the original state. Random 128-bit states checked against a software model (≥1000 vectors).
- Continuous streaming: in_valid and out_ready held high → one result every 6 cycles, all matching the model.
